multichannel_linear_interpolator: RTL and testbench

Parametrised successor of the stereo linear interpolator (sample-rate converter front end).
- Measures the input sample period in clocks.
- Generates the fixed output-rate strobe internally.
- For every output tick, computes one linearly interpolated output sample per channel from the two most recent input samples.
- Sits between the I2S/SPDIF receiver and the downstream DSP chain; channel count, widths and output rate are generics.

---
 rtl/multichannel_linear_interpolator.sv | 236 +++++++++++++++++++++++
 tb/tb_multichannel_linear_interpolator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_linear_interpolator.sv
// Multichannel linear interpolator: measures the input sample period, generates the output-rate tick,
// and produces one linearly interpolated sample per channel for each tick. Optional macro: INTERP_ROUND_EN.
module multichannel_linear_interpolator #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned FRAC_W   = 10,
  parameter int unsigned OUT_DIV  = 512
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       run,
  input  logic                       din_valid,
  input  logic [CHANNELS*DATA_W-1:0] din,
  output logic                       dout_valid,
  output logic [CHANNELS*DATA_W-1:0] dout,
  output logic                       busy,
  output logic [CNT_W-1:0]           period,
  output logic                       overrun
);
  localparam int unsigned VEC_W  = CHANNELS * DATA_W;
  localparam int unsigned DIFF_W = DATA_W + 1;
  localparam int unsigned PROD_W = DATA_W + FRAC_W + 2;
  localparam int unsigned REM_W  = CNT_W + 1;
  localparam int unsigned DIV_W  = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned STEP_W = $clog2(FRAC_W + 1);

  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(OUT_DIV - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CHANNELS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FRAC_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_MAC, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      elapsed_q, elapsed_d;
  logic [CNT_W-1:0]      period_q, period_d;
  logic [1:0]            primed_q, primed_d;
  logic [VEC_W-1:0]      prev_q, prev_d, cur_q, cur_d;
  logic [VEC_W-1:0]      prev_s_q, prev_s_d, cur_s_q, cur_s_d;
  logic [CNT_W-1:0]      p_s_q, p_s_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [FRAC_W-1:0]     frac_q, frac_d;
  logic                  spec_q, spec_d;
  logic [VEC_W-1:0]      y_q, y_d;
  logic [VEC_W-1:0]      dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic                  tick_c;
  logic [REM_W-1:0]      rem_sh_c;
  logic signed [DATA_W-1:0] prev_ch_c, cur_ch_c, y_c;
  logic signed [DIFF_W-1:0] diff_c;
  logic signed [PROD_W-1:0] prod_c, prod_sh_c;

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign period     = period_q;
  assign overrun    = overrun_q;

  // Next-state, datapath and output logic
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    ch_d         = ch_q;
    elapsed_d    = elapsed_q;
    period_d     = period_q;
    primed_d     = primed_q;
    prev_d       = prev_q;
    cur_d        = cur_q;
    prev_s_d     = prev_s_q;
    cur_s_d      = cur_s_q;
    p_s_d        = p_s_q;
    rem_d        = rem_q;
    frac_d       = frac_q;
    spec_d       = spec_q;
    y_d          = y_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overrun_d    = overrun_q;

    tick_c = run && (div_q == LAST_DIV);
    div_d  = (div_q == LAST_DIV) ? '0 : div_q + DIV_W'(1);

    // One channel of prev + floor(diff*frac / 2^FRAC_W); the result stays between prev and cur
    prev_ch_c = prev_s_q[ch_q*DATA_W +: DATA_W];
    cur_ch_c  = cur_s_q[ch_q*DATA_W +: DATA_W];
    diff_c    = DIFF_W'(cur_ch_c) - DIFF_W'(prev_ch_c);
    prod_c    = PROD_W'(diff_c) * PROD_W'($signed({1'b0, frac_q}));
`ifdef INTERP_ROUND_EN
    prod_c    = prod_c + (PROD_W'(1) <<< (FRAC_W - 1));
`endif
    prod_sh_c = prod_c >>> FRAC_W;
    y_c       = DATA_W'(PROD_W'(prev_ch_c) + prod_sh_c);
    rem_sh_c  = {rem_q, 1'b0};

    if (din_valid) begin
      prev_d    = cur_q;
      cur_d     = din;
      period_d  = elapsed_q;
      elapsed_d = '0;
      primed_d  = (primed_q == 2'd2) ? 2'd2 : primed_q + 2'd1;
    end else if (elapsed_q != '1) begin
      elapsed_d = elapsed_q + CNT_W'(1);
    end

    if (tick_c && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick_c && (primed_q == 2'd2)) begin
          state_d  = S_DIV;
          step_d   = '0;
          prev_s_d = prev_q;
          cur_s_d  = cur_q;
          p_s_d    = period_q;
          rem_d    = elapsed_q;
          frac_d   = '0;
          spec_d   = 1'b0;
          if (period_q == '0) begin
            spec_d = 1'b1;
          end else if (elapsed_q >= period_q) begin
            frac_d = '1;
            spec_d = 1'b1;
          end
        end
      end
      S_DIV: begin
        // Restoring division: one quotient bit of e*2^FRAC_W/P per cycle
        if (!spec_q) begin
          if (rem_sh_c >= {1'b0, p_s_q}) begin
            rem_d  = CNT_W'(rem_sh_c - {1'b0, p_s_q});
            frac_d = {frac_q[FRAC_W-2:0], 1'b1};
          end else begin
            rem_d  = rem_sh_c[CNT_W-1:0];
            frac_d = {frac_q[FRAC_W-2:0], 1'b0};
          end
        end
        if (step_q == LAST_STEP) begin
          state_d = S_MAC;
          ch_d    = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_MAC: begin
        y_d[ch_q*DATA_W +: DATA_W] = y_c;
        if (ch_q == LAST_CH) state_d = S_OUT;
        else                 ch_d    = ch_q + CH_W'(1);
      end
      S_OUT: begin
        dout_d       = y_q;
        dout_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Soft reset: everything clears except the last output sample
    if (!run) begin
      state_d      = S_IDLE;
      step_d       = '0;
      ch_d         = '0;
      div_d        = '0;
      elapsed_d    = '0;
      period_d     = '0;
      primed_d     = '0;
      prev_d       = '0;
      cur_d        = '0;
      prev_s_d     = '0;
      cur_s_d      = '0;
      p_s_d        = '0;
      rem_d        = '0;
      frac_d       = '0;
      spec_d       = 1'b0;
      y_d          = '0;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      ch_q         <= '0;
      div_q        <= '0;
      elapsed_q    <= '0;
      period_q     <= '0;
      primed_q     <= '0;
      prev_q       <= '0;
      cur_q        <= '0;
      prev_s_q     <= '0;
      cur_s_q      <= '0;
      p_s_q        <= '0;
      rem_q        <= '0;
      frac_q       <= '0;
      spec_q       <= 1'b0;
      y_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      ch_q         <= ch_d;
      div_q        <= div_d;
      elapsed_q    <= elapsed_d;
      period_q     <= period_d;
      primed_q     <= primed_d;
      prev_q       <= prev_d;
      cur_q        <= cur_d;
      prev_s_q     <= prev_s_d;
      cur_s_q      <= cur_s_d;
      p_s_q        <= p_s_d;
      rem_q        <= rem_d;
      frac_q       <= frac_d;
      spec_q       <= spec_d;
      y_q          <= y_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_multichannel_linear_interpolator.sv
// Directed, table-driven bench for multichannel_linear_interpolator (default build and INTERP_ROUND_EN).
module tb_multichannel_linear_interpolator;
  localparam int unsigned DW = 24;
  localparam int unsigned VW = 2 * DW;

  logic          clk, reset_n, run, din_valid;
  logic [VW-1:0] din, dout;
  logic          dout_valid, busy, overrun;
  logic [10:0]   period;

  logic          run8, din_valid8;
  logic [VW-1:0] din8, dout8;
  logic          dout_valid8, busy8, overrun8;
  logic [10:0]   period8;

  int npass = 0;
  int ntot  = 0;

  multichannel_linear_interpolator dut (
    .clk(clk), .reset_n(reset_n), .run(run), .din_valid(din_valid), .din(din),
    .dout_valid(dout_valid), .dout(dout), .busy(busy), .period(period), .overrun(overrun)
  );

  multichannel_linear_interpolator #(.OUT_DIV(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .run(run8), .din_valid(din_valid8), .din(din8),
    .dout_valid(dout_valid8), .dout(dout8), .busy(busy8), .period(period8), .overrun(overrun8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] prev_v;
    logic [VW-1:0] cur_v;
    logic [VW-1:0] nxt_v;
    logic [VW-1:0] exp_t;
    logic [VW-1:0] exp_r;
    int            p;
    int            e;
    bit            coinc;
  } vec_t;

  vec_t          vecs[7];
  logic [VW-1:0] last_exp;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic restart();
    run = 1'b0;
    din_valid = 1'b0;
    cyc();
    cyc();
    run = 1'b1;
  endtask

  // Edge k counts from the first edge with run high; ticks fall on edges 512, 1024, ...
  task automatic run_vec(input vec_t v, input int idx);
    int t, x, y;
    logic [VW-1:0] exp;
`ifdef INTERP_ROUND_EN
    exp = v.exp_r;
`else
    exp = v.exp_t;
`endif
    t = 512;
    while (t - v.e - v.p - 2 < 2) t += 512;
    y = t - v.e - 1;
    x = y - v.p - 1;
    restart();
    for (int k = 1; k <= t + 13; k++) begin
      din_valid = (k == x) || (k == y) || (v.coinc && (k == t));
      din = (k == x) ? v.prev_v : ((k == y) ? v.cur_v : v.nxt_v);
      cyc();
      if (k == t + 12) chk($sformatf("v%0d_valid_early", idx), VW'(dout_valid), '0);
      if (k == t + 13) begin
        chk($sformatf("v%0d_valid", idx), VW'(dout_valid), VW'(1));
        chk($sformatf("v%0d_dout", idx), dout, exp);
        chk($sformatf("v%0d_period", idx), VW'(period), VW'(v.coinc ? v.e : v.p));
        chk($sformatf("v%0d_overrun", idx), VW'(overrun), '0);
      end
    end
    din_valid = 1'b0;
    last_exp = exp;
  endtask

  initial begin
    int first, cnt;

    vecs[0] = '{prev_v: {24'h000010, 24'h000000}, cur_v: {24'h000020, 24'h001000}, nxt_v: '0,
                exp_t: {24'h000018, 24'h000800}, exp_r: {24'h000018, 24'h000800}, p: 1024, e: 512, coinc: 1'b0};
    vecs[1] = '{prev_v: {24'hFFFFF0, 24'h000100}, cur_v: {24'h000010, 24'hFFFF00}, nxt_v: '0,
                exp_t: {24'hFFFFF8, 24'h000080}, exp_r: {24'hFFFFF8, 24'h000080}, p: 1024, e: 256, coinc: 1'b0};
    vecs[2] = '{prev_v: {24'h000003, 24'h000000}, cur_v: {24'hFFFFFF, 24'h000400}, nxt_v: '0,
                exp_t: {24'hFFFFFF, 24'h0003FF}, exp_r: {24'hFFFFFF, 24'h0003FF}, p: 1024, e: 1100, coinc: 1'b0};
    vecs[3] = '{prev_v: {24'hABCDEF, 24'h123456}, cur_v: {24'h111111, 24'h000000}, nxt_v: '0,
                exp_t: {24'hABCDEF, 24'h123456}, exp_r: {24'hABCDEF, 24'h123456}, p: 0, e: 100, coinc: 1'b0};
    vecs[4] = '{prev_v: {24'h000064, 24'h000000}, cur_v: {24'h000000, 24'h000002}, nxt_v: '0,
                exp_t: {24'h000042, 24'h000000}, exp_r: {24'h000043, 24'h000001}, p: 3, e: 1, coinc: 1'b0};
    vecs[5] = '{prev_v: {24'h000000, 24'h000000}, cur_v: {24'hFFFC00, 24'h000200}, nxt_v: {24'h7FFFFF, 24'h7FFFFF},
                exp_t: {24'hFFFD00, 24'h000180}, exp_r: {24'hFFFD00, 24'h000180}, p: 1024, e: 768, coinc: 1'b1};
    vecs[6] = '{prev_v: {24'h7FFFFF, 24'h000000}, cur_v: {24'h800000, 24'h000800}, nxt_v: '0,
                exp_t: {24'h803FFF, 24'h0007FE}, exp_r: {24'h804000, 24'h0007FE}, p: 1024, e: 1024, coinc: 1'b0};

    reset_n = 1'b0; run = 1'b0; din_valid = 1'b0; din = '0;
    run8 = 1'b0; din_valid8 = 1'b0; din8 = '0;
    last_exp = '0;
    cyc();
    cyc();
    chk("rst_dout", dout, '0);
    chk("rst_valid", VW'(dout_valid), '0);
    chk("rst_busy", VW'(busy), '0);
    chk("rst_period", VW'(period), '0);
    chk("rst_overrun", VW'(overrun), '0);
    reset_n = 1'b1;

    // Startup: ticks before the second input sample are ignored
    restart();
    first = -1;
    cnt = 0;
    for (int k = 1; k <= 1560; k++) begin
      din_valid = (k == 100) || (k == 1100);
      din = (k == 100) ? '0 : {24'h000010, 24'h000400};
      cyc();
      if (dout_valid) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k == 1099) begin
        chk("startup_no_valid", VW'(cnt), '0);
        chk("startup_overrun", VW'(overrun), '0);
      end
    end
    din_valid = 1'b0;
    chk("startup_first_valid", VW'(first), VW'(1549));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // run low mid-computation: abort, dout holds
    restart();
    for (int k = 1; k <= 519; k++) begin
      din_valid = (k == 10) || (k == 20);
      din = (k == 10) ? '0 : {24'h000100, 24'h000100};
      cyc();
    end
    din_valid = 1'b0;
    chk("runlow_busy_before", VW'(busy), VW'(1));
    run = 1'b0;
    cyc();
    chk("runlow_busy", VW'(busy), '0);
    chk("runlow_dout_hold", dout, last_exp);
    chk("runlow_valid", VW'(dout_valid), '0);
    run = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (dout_valid) cnt++;
    end
    chk("runlow_no_valid", VW'(cnt), '0);

    // reset_n low during DIV
    restart();
    for (int k = 1; k <= 514; k++) begin
      din_valid = (k == 10) || (k == 20);
      din = (k == 10) ? '0 : {24'h000100, 24'h000100};
      cyc();
    end
    din_valid = 1'b0;
    chk("rdiv_busy_before", VW'(busy), VW'(1));
    chk("rdiv_period_before", VW'(period), VW'(9));
    reset_n = 1'b0;
    cyc();
    chk("rdiv_busy", VW'(busy), '0);
    chk("rdiv_dout", dout, '0);
    chk("rdiv_valid", VW'(dout_valid), '0);
    chk("rdiv_period", VW'(period), '0);
    chk("rdiv_overrun", VW'(overrun), '0);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (dout_valid) cnt++;
    end
    chk("rdiv_no_valid", VW'(cnt), '0);

    // OUT_DIV=8: tick while busy is dropped and sets overrun
    run8 = 1'b1;
    cnt = 0;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      din_valid8 = (k == 1) || (k == 3);
      din8 = (k == 1) ? '0 : {24'h000000, 24'h000400};
      cyc();
      if (dout_valid8) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k == 15) chk("ovr_before", VW'(overrun8), '0);
      if (k == 16) chk("ovr_set", VW'(overrun8), VW'(1));
      if (k == 21) begin
        chk("ovr_dout", dout8, {24'h000000, 24'h0003FF});
        chk("ovr_period", VW'(period8), VW'(1));
      end
    end
    din_valid8 = 1'b0;
    chk("ovr_valid_count", VW'(cnt), VW'(2));
    chk("ovr_first_valid", VW'(first), VW'(21));
    run8 = 1'b0;
    cyc();
    chk("ovr_cleared", VW'(overrun8), '0);
    chk("ovr_busy_cleared", VW'(busy8), '0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
